// File: rtl/dual_master_bus_arbiter_if.sv
// Bus bundle between the two masters and the arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface dual_master_bus_arbiter_if #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned NUM_SLAVES = 3
);
    logic                  m1_req;
    logic [ADDR_W-1:0]     m1_addr;
    logic                  m1_done;
    logic                  m2_req;
    logic [ADDR_W-1:0]     m2_addr;
    logic                  m2_done;
    logic                  m1_grant;
    logic                  m2_grant;
    logic                  bus_owner;
    logic [NUM_SLAVES-1:0] slave_sel;
    logic                  addr_err;
    logic                  timeout;

    modport master (
        output m1_req, m1_addr, m1_done, m2_req, m2_addr, m2_done,
        input  m1_grant, m2_grant, bus_owner, slave_sel, addr_err, timeout
    );

    modport slave (
        input  m1_req, m1_addr, m1_done, m2_req, m2_addr, m2_done,
        output m1_grant, m2_grant, bus_owner, slave_sel, addr_err, timeout
    );
endinterface

// File: rtl/dual_master_bus_arbiter.sv
// Round-robin arbiter for two bus masters with one-hot slave decode and registered outputs.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module dual_master_bus_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned SLV_BITS   = 2,
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    dual_master_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOwnM1, StOwnM2, StHandover} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_last_owner, w_last_owner_nxt;  // 0 = M1, 1 = M2
    logic [1:0]            r_mask, w_mask_nxt, w_mask_set;
    logic                  r_m1_grant, r_m2_grant;
    logic                  r_bus_owner, w_bus_owner_nxt;
    logic [NUM_SLAVES-1:0] r_slave_sel, w_slave_sel_nxt;
    logic                  r_addr_err, w_addr_err_nxt;
    logic                  r_timeout, w_timeout_nxt;

    logic [1:0]            w_req, w_done, w_elig;
    logic                  w_winner, w_own_idx, w_idx_ok, w_unused;
    logic [ADDR_W-1:0]     w_win_addr;
    logic [SLV_BITS-1:0]   w_idx;
    logic [NUM_SLAVES-1:0] w_dec;

    assign w_req    = {bus.m2_req, bus.m1_req};
    assign w_done   = {bus.m2_done, bus.m1_done};
    assign w_elig   = w_req & ~r_mask;
    assign w_unused = ^{bus.m1_addr[ADDR_W-SLV_BITS-1:0], bus.m2_addr[ADDR_W-SLV_BITS-1:0]};

    // On a tie the master that did not win last time goes first.
    always_comb begin
        w_winner = w_elig[1];
        if (w_elig == 2'b11) begin
            w_winner = ~r_last_owner;
        end
    end

    assign w_win_addr = w_winner ? bus.m2_addr : bus.m1_addr;
    assign w_idx      = w_win_addr[ADDR_W-1 -: SLV_BITS];
    assign w_idx_ok   = (32'(w_idx) < NUM_SLAVES);
    assign w_own_idx  = (r_state == StOwnM2);

    always_comb begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            w_dec[i] = (32'(w_idx) == i);
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            w_expired;
    assign w_expired = (r_cnt == CntW'(TIMEOUT - 1));
`else
    logic w_expired;
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_bus_owner_nxt  = r_bus_owner;
        w_slave_sel_nxt  = r_slave_sel;
        w_addr_err_nxt   = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_mask_set       = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (|w_elig) begin
                    w_last_owner_nxt = w_winner;
                    if (w_idx_ok) begin
                        w_state_nxt     = w_winner ? StOwnM2 : StOwnM1;
                        w_slave_sel_nxt = w_dec;
                        w_bus_owner_nxt = w_winner;
                    end else begin
                        w_addr_err_nxt = 1'b1;
                        w_mask_set     = w_winner ? 2'b10 : 2'b01;
                    end
                end
            end
            StOwnM1, StOwnM2: begin
                if (w_done[w_own_idx] || !w_req[w_own_idx]) begin
                    w_state_nxt = StHandover;
                end else if (w_expired) begin
                    w_state_nxt   = StHandover;
                    w_timeout_nxt = 1'b1;
                    w_mask_set    = w_own_idx ? 2'b10 : 2'b01;
                end
            end
            StHandover: w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
        if (w_state_nxt != StOwnM1 && w_state_nxt != StOwnM2) begin
            w_slave_sel_nxt = '0;
        end
        // A mask lasts until the masked master lets go of its request.
        w_mask_nxt = (r_mask & w_req) | w_mask_set;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_last_owner <= 1'b1;
            r_mask       <= 2'b00;
            r_m1_grant   <= 1'b0;
            r_m2_grant   <= 1'b0;
            r_bus_owner  <= 1'b0;
            r_slave_sel  <= '0;
            r_addr_err   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_mask       <= w_mask_nxt;
            r_m1_grant   <= (w_state_nxt == StOwnM1);
            r_m2_grant   <= (w_state_nxt == StOwnM2);
            r_bus_owner  <= w_bus_owner_nxt;
            r_slave_sel  <= w_slave_sel_nxt;
            r_addr_err   <= w_addr_err_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counts cycles spent in the current ownership; restarts on every new grant.
    always_comb begin
        w_cnt_nxt = '0;
        if ((r_state == StOwnM1 || r_state == StOwnM2) && w_state_nxt == r_state) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign bus.m1_grant  = r_m1_grant;
    assign bus.m2_grant  = r_m2_grant;
    assign bus.bus_owner = r_bus_owner;
    assign bus.slave_sel = r_slave_sel;
    assign bus.addr_err  = r_addr_err;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_dual_master_bus_arbiter.sv
// Scoreboard bench for dual_master_bus_arbiter: a transaction-level model predicts every cycle's
// outputs into a queue, a negedge monitor pops and compares against the DUT.
module tb_dual_master_bus_arbiter;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned SLV_BITS   = 2;
    localparam int unsigned NUM_SLAVES = 3;
    localparam int unsigned TIMEOUT    = 64;
    localparam int unsigned OW         = NUM_SLAVES + 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [OW-1:0] exp_q[$];
    bit   pend_drop[2];

    dual_master_bus_arbiter_if #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) bus ();

    dual_master_bus_arbiter #(
        .ADDR_W(ADDR_W), .SLV_BITS(SLV_BITS), .NUM_SLAVES(NUM_SLAVES), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] dut_outputs();
        return {bus.m1_grant, bus.m2_grant, bus.bus_owner, bus.slave_sel, bus.addr_err, bus.timeout};
    endfunction

    // Reference model: who owns the bus, how long until arbitration may run again,
    // which masters are locked out, and who won last.
    int                    owner = -1;
    int                    gap   = 0;
    int                    held  = 0;
    bit                    prev  = 1'b1;
    bit                    mux   = 1'b0;
    bit                    blocked[2];
    logic [NUM_SLAVES-1:0] sel_m = '0;

    always @(posedge clk) begin : model
        bit rq[2];
        bit dn[2];
        int ad[2];
        bit err, to, c0, c1;
        int w, idx, set_blk;
        logic [OW-1:0] e;
        rq[0] = bus.m1_req;  rq[1] = bus.m2_req;
        dn[0] = bus.m1_done; dn[1] = bus.m2_done;
        ad[0] = int'(bus.m1_addr); ad[1] = int'(bus.m2_addr);
        err = 0; to = 0; set_blk = -1;
        if (reset) begin
            owner = -1; gap = 0; prev = 1'b1; mux = 1'b0;
            blocked[0] = 0; blocked[1] = 0;
        end else begin
            if (owner >= 0) begin
                if (dn[owner] || !rq[owner]) begin
                    owner = -1; gap = 1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (held == int'(TIMEOUT)) begin
                    to = 1; set_blk = owner; owner = -1; gap = 1;
                end
`endif
                else begin
                    held++;
                end
            end else if (gap > 0) begin
                gap--;
            end else begin
                c0 = rq[0] && !blocked[0];
                c1 = rq[1] && !blocked[1];
                if (c0 || c1) begin
                    if (c0 && c1) w = prev ? 0 : 1;
                    else          w = c1 ? 1 : 0;
                    idx  = ad[w] >> (ADDR_W - SLV_BITS);
                    prev = (w == 1);
                    if (idx < int'(NUM_SLAVES)) begin
                        owner = w; held = 1; mux = (w == 1);
                        sel_m = NUM_SLAVES'(1) << idx;
                    end else begin
                        err = 1; set_blk = w;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                blocked[i] = blocked[i] && rq[i];
                if (set_blk == i) blocked[i] = 1;
            end
        end
        e = {(owner == 0), (owner == 1), mux, (owner >= 0) ? sel_m : NUM_SLAVES'(0), err, to};
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        logic [OW-1:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = dut_outputs();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t {g1,g2,owner,sel,err,to} actual=%b required=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Async reset between edges: outputs must clear without waiting for a clock.
    task automatic reset_mid();
        reset = 1'b1;
        #1;
        checks++;
        if (dut_outputs() !== '0) begin
            errors++;
            $display("FAIL async_reset actual=%b required=%b", dut_outputs(), {OW{1'b0}});
        end
        step(2);
        reset = 1'b0;
    endtask

    task automatic finish_owner(input int limit);
        int k = 0;
        while (!bus.m1_grant && !bus.m2_grant && k < limit) begin
            step(1);
            k++;
        end
        checks++;
        if (!bus.m1_grant && !bus.m2_grant) begin
            errors++;
            $display("FAIL wait_grant actual=no grant after %0d cycles required=grant", limit);
        end else if (bus.m1_grant) begin
            bus.m1_done = 1'b1; step(1); bus.m1_done = 1'b0; bus.m1_req = 1'b0;
        end else begin
            bus.m2_done = 1'b1; step(1); bus.m2_done = 1'b0; bus.m2_req = 1'b0;
        end
    endtask

    task automatic rand_master(input int i);
        bit req, done, grant;
        logic [ADDR_W-1:0] addr;
        req   = i ? bus.m2_req  : bus.m1_req;
        addr  = i ? bus.m2_addr : bus.m1_addr;
        grant = i ? bus.m2_grant : bus.m1_grant;
        done  = 1'b0;
        if (pend_drop[i]) begin
            req = 1'b0; pend_drop[i] = 1'b0;
        end else if (!req) begin
            if ($urandom_range(3) == 0) begin
                req = 1'b1; addr = ADDR_W'($urandom);
            end
        end else if (grant && $urandom_range(7) < 2) begin
            done = 1'b1; pend_drop[i] = 1'b1;
        end else if ($urandom_range(31) == 0) begin
            req = 1'b0;
        end else if (grant && $urandom_range(7) == 0) begin
            addr = ADDR_W'($urandom);
        end else if (!grant && $urandom_range(15) == 0) begin
            done = 1'b1;
        end
        if (i == 0) begin
            bus.m1_req = req; bus.m1_addr = addr; bus.m1_done = done;
        end else begin
            bus.m2_req = req; bus.m2_addr = addr; bus.m2_done = done;
        end
    endtask

    initial begin
        bus.m1_req = 0; bus.m1_addr = '0; bus.m1_done = 0;
        bus.m2_req = 0; bus.m2_addr = '0; bus.m2_done = 0;
        step(3);
        reset = 1'b0;
        step(2);

        // Single master, slave 0.
        bus.m1_req = 1; bus.m1_addr = 14'd1001;
        step(3);
        finish_owner(5);
        step(3);

        // M2 on slave 2; M1 arrives mid-grant and waits for the handover.
        bus.m2_req = 1; bus.m2_addr = 14'd9193;
        step(2);
        bus.m1_req = 1; bus.m1_addr = 14'd500;
        step(3);
        finish_owner(5);
        step(4);
        finish_owner(5);
        step(3);

        // Tie straight after reset, then alternating ties.
        reset_mid();
        bus.m1_req = 1; bus.m1_addr = 14'd5097;
        bus.m2_req = 1; bus.m2_addr = 14'd5098;
        step(2);
        finish_owner(5);
        step(1);
        finish_owner(5);
        bus.m1_req = 1; bus.m2_req = 1;
        step(3);
        finish_owner(5);
        finish_owner(6);
        step(3);

        // Invalid slave index from M1 with concurrent M2.
        bus.m1_req = 1; bus.m1_addr = 14'd13000;
        bus.m2_req = 1; bus.m2_addr = 14'd200;
        step(3);
        finish_owner(5);
        step(4);
        bus.m1_req = 0;
        step(3);

        // Reset while M1 owns the bus; M1 keeps requesting and is granted again.
        bus.m1_req = 1; bus.m1_addr = 14'd1001;
        step(2);
        reset_mid();
        step(2);
        finish_owner(5);
        step(3);

        // Long hold with M2 pending: watchdog revokes only when enabled.
        bus.m1_req = 1; bus.m1_addr = 14'd1001;
        step(2);
        bus.m2_req = 1; bus.m2_addr = 14'd9193;
        step(70);
`ifdef ARB_TIMEOUT_EN
        bus.m1_req = 0;
        finish_owner(5);
`else
        finish_owner(5);
        finish_owner(6);
`endif
        step(4);

        for (int c = 0; c < 3000; c++) begin
            step(1);
            rand_master(0);
            rand_master(1);
            if ($urandom_range(499) == 0) reset_mid();
        end

        bus.m1_req = 0; bus.m1_done = 0;
        bus.m2_req = 0; bus.m2_done = 0;
        step(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
